// File: rtl/uart_cmd_pkg.sv
// Shared types and byte constants for the UART command bridge.
package uart_cmd_pkg;

    // Bridge FSM states: idle hunt, four frame-byte collectors, check, bus, respond.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_CMD  = 3'd1,
        ST_GET_ADDR = 3'd2,
        ST_GET_DATA = 3'd3,
        ST_GET_CSUM = 3'd4,
        ST_CHECK    = 3'd5,
        ST_BUS      = 3'd6,
        ST_SEND     = 3'd7
    } state_t;

    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    // True in the states that collect one frame byte each.
    function automatic logic is_get_state(state_t s);
        return (s == ST_GET_CMD) || (s == ST_GET_ADDR) ||
               (s == ST_GET_DATA) || (s == ST_GET_CSUM);
    endfunction

    // True in every state that is allowed to pop the rx FIFO.
    function automatic logic is_rx_state(state_t s);
        return (s == ST_IDLE) || is_get_state(s);
    endfunction

endpackage

// File: rtl/uart_cmd_bridge.sv
// UART command bridge: parses SYNC/CMD/ADDR/DATA/CSUM frames from the rx FIFO,
// performs one 8-bit register access on a req/ack bus and answers through the
// tx FIFO with ACK (plus read data) or NAK.
module uart_cmd_bridge
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         IDLE_TO   = 5_000_000,
    parameter int         IDLE_TO_W = 23,
    parameter int         ACK_TO    = 255,
    parameter int         ACK_TO_W  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       reg_req,
    output logic       reg_we,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    input  logic       reg_ack,
    output logic       busy
);

    // Terminal values of the two saturating counters.
    localparam logic [IDLE_TO_W-1:0] TO_LAST  = IDLE_TO_W'(IDLE_TO - 1);
    localparam logic [ACK_TO_W-1:0]  ACK_LAST = ACK_TO_W'(ACK_TO - 1);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [7:0]           r_cmd;
    logic [7:0]           r_addr;
    logic [7:0]           r_data;
    logic [7:0]           r_csum;

    logic [7:0]           r_buf0;
    logic [7:0]           r_buf1;
    logic                 r_len2;
    logic                 r_idx;

    logic [IDLE_TO_W-1:0] r_to_cnt;
    logic [ACK_TO_W-1:0]  r_ack_cnt;

    logic                 w_pop;
    logic                 w_frame_ok;
    logic                 w_to_hit;
    logic                 w_ack_expire;
    logic                 w_push;
    logic                 w_last_push;

    // A pop happens whenever a byte is waiting and the FSM is collecting;
    // reset_n keeps the strobe low while the block is held in reset.
    assign w_pop        = reset_n && !rx_empty && is_rx_state(r_state);
    assign w_frame_ok   = ((r_cmd ^ r_addr ^ r_data) == r_csum) &&
                          ((r_cmd == CMD_WR) || (r_cmd == CMD_RD));
    assign w_to_hit     = is_get_state(r_state) && !w_pop && (r_to_cnt == TO_LAST);
    assign w_ack_expire = (r_state == ST_BUS) && !reg_ack && (r_ack_cnt == ACK_LAST);
    assign w_push       = (r_state == ST_SEND) && !tx_full;
    // r_idx reaches r_len2 on the final byte (0 for one-byte, 1 for two-byte replies).
    assign w_last_push  = w_push && (r_idx == r_len2);

    // State register; reset returns to IDLE at once, which also drops reg_req.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and all bus/FIFO strobes derived from the current state.
    always_comb begin
        w_state_nxt = r_state;
        rd_uart     = w_pop;
        wr_uart     = w_push;
        w_data      = 8'h00;
        reg_req     = 1'b0;
        reg_we      = 1'b0;
        reg_addr    = 8'h00;
        reg_wdata   = 8'h00;
        busy        = (r_state != ST_IDLE);

        if (r_state == ST_SEND) begin
            w_data = r_idx ? r_buf1 : r_buf0;
        end
        if (r_state == ST_BUS) begin
            reg_req   = 1'b1;
            reg_we    = (r_cmd == CMD_WR);
            reg_addr  = r_addr;
            reg_wdata = r_data;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_pop && (rx_data == SYNC_BYTE)) w_state_nxt = ST_GET_CMD;
            end
            ST_GET_CMD: begin
                if (w_pop)         w_state_nxt = ST_GET_ADDR;
                else if (w_to_hit) w_state_nxt = ST_IDLE;
            end
            ST_GET_ADDR: begin
                if (w_pop)         w_state_nxt = ST_GET_DATA;
                else if (w_to_hit) w_state_nxt = ST_IDLE;
            end
            ST_GET_DATA: begin
                if (w_pop)         w_state_nxt = ST_GET_CSUM;
                else if (w_to_hit) w_state_nxt = ST_IDLE;
            end
            ST_GET_CSUM: begin
                if (w_pop)         w_state_nxt = ST_CHECK;
                else if (w_to_hit) w_state_nxt = ST_IDLE;
            end
            ST_CHECK: begin
                w_state_nxt = w_frame_ok ? ST_BUS : ST_SEND;
            end
            ST_BUS: begin
                if (reg_ack || w_ack_expire) w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_last_push) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch each frame byte in the cycle it is popped; SYNC values mid-frame are plain data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd  <= 8'h00;
            r_addr <= 8'h00;
            r_data <= 8'h00;
            r_csum <= 8'h00;
        end else if (w_pop) begin
            case (r_state)
                ST_GET_CMD:  r_cmd  <= rx_data;
                ST_GET_ADDR: r_addr <= rx_data;
                ST_GET_DATA: r_data <= rx_data;
                ST_GET_CSUM: r_csum <= rx_data;
                default: ;
            endcase
        end
    end

    // Inter-byte timeout: cleared by every pop and outside frame collection, saturates at its terminal value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (!is_get_state(r_state) || w_pop) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_LAST) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Ack-wait counter: runs only while the bus request is up, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_cnt <= '0;
        end else if (r_state != ST_BUS) begin
            r_ack_cnt <= '0;
        end else if (r_ack_cnt != ACK_LAST) begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
        end
    end

    // Response buffer: loaded on the way into SEND, then walked one byte per accepted push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf0 <= 8'h00;
            r_buf1 <= 8'h00;
            r_len2 <= 1'b0;
            r_idx  <= 1'b0;
        end else begin
            if ((r_state == ST_CHECK) && !w_frame_ok) begin
                r_buf0 <= RSP_NAK;
                r_len2 <= 1'b0;
                r_idx  <= 1'b0;
            end else if ((r_state == ST_BUS) && reg_ack) begin
                r_buf0 <= RSP_ACK;
                r_buf1 <= reg_rdata;
                r_len2 <= (r_cmd == CMD_RD);
                r_idx  <= 1'b0;
            end else if (w_ack_expire) begin
                r_buf0 <= RSP_NAK;
                r_len2 <= 1'b0;
                r_idx  <= 1'b0;
            end else if (w_push && !w_last_push) begin
                r_idx  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: FIFO and register-slave models,
// a vector table of single frames, hand sequences for timeouts/stall/reset,
// and a randomized frame stream checked against a frame-level parser model.
module tb_uart_cmd_bridge;

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         IDLE_TO = 300;
    localparam int         ACK_TO  = 255;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_empty, rd_uart, tx_full, wr_uart;
    logic [7:0] rx_data, w_data;
    logic       reg_req, reg_we, reg_ack, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    uart_cmd_bridge #(
        .SYNC_BYTE (SYNC),
        .IDLE_TO   (IDLE_TO),
        .IDLE_TO_W (9),
        .ACK_TO    (ACK_TO),
        .ACK_TO_W  (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_empty  (rx_empty),
        .rx_data   (rx_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .w_data    (w_data),
        .reg_req   (reg_req),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       acked;
        int         cycles;
    } bus_t;

    // Environment state
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    bus_t       bus_log[$];
    bus_t       cur;
    bit         pop_pending = 0;
    bit         gap_rand = 0, txf_rand = 0, txf_force = 0, slave_by_addr = 0;
    int         ack_lat = 0;
    logic [7:0] slave_rdata = 8'h00;
    int         req_cycles = 0, lat = 0, cyc = 0, viol = 0;
    int         ack_cyc = -1, first_wr_cyc = -1, sync_pop_cyc = -1, req_rise_cyc = -1;

    int n_chk = 0, n_pass = 0;

    function automatic logic [7:0] rdata_of(logic [7:0] a);
        return a ^ 8'hC3;
    endfunction

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        tx_log.delete();
        bus_log.delete();
        ack_cyc = -1; first_wr_cyc = -1; sync_pop_cyc = -1; req_rise_cyc = -1;
    endtask

    task automatic wait_done(int max_cyc, string name);
        int quiet = 0;
        for (int k = 0; k < max_cyc; k++) begin
            step(1);
            if (rx_q.size() == 0 && !pop_pending && !busy) quiet++;
            else quiet = 0;
            if (quiet >= 3) return;
        end
        check({name, "_done_timeout"}, 1, 0);
    endtask

    // FIFO and register-slave model: inputs change only at negedge, outputs sampled 1 time unit later.
    initial begin : env
        rx_empty = 1'b1; rx_data = 8'h00; tx_full = 1'b0; reg_ack = 1'b0; reg_rdata = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (pop_pending && rx_q.size() > 0) void'(rx_q.pop_front());
            pop_pending = 0;
            rx_empty = (rx_q.size() == 0) || (gap_rand && $urandom_range(3) == 0);
            rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            tx_full  = txf_force || (txf_rand && $urandom_range(2) == 0);
            if (reg_req) begin
                req_cycles++;
                if (req_cycles == 1) begin
                    cur.we = reg_we; cur.addr = reg_addr; cur.wdata = reg_wdata;
                    cur.acked = 1'b0; cur.cycles = 0; req_rise_cyc = cyc;
                end else if (reg_we != cur.we || reg_addr != cur.addr || reg_wdata != cur.wdata) begin
                    viol++;
                end
                lat = slave_by_addr ? int'(cur.addr[1:0]) : ack_lat;
                reg_ack   = (lat >= 0) && (req_cycles == lat + 1);
                reg_rdata = slave_by_addr ? rdata_of(cur.addr) : slave_rdata;
            end else begin
                reg_ack = 1'b0;
                if (req_cycles > 0) begin
                    cur.cycles = req_cycles;
                    bus_log.push_back(cur);
                    req_cycles = 0;
                end
            end
            #1;
            if (rd_uart) begin
                if (rx_empty) viol++;
                if (reg_req) viol++;
                pop_pending = 1;
                if (!busy && rx_data == SYNC) sync_pop_cyc = cyc;
            end
            if (wr_uart) begin
                if (tx_full || reg_req) viol++;
                tx_log.push_back(w_data);
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
            end
            if (reg_req && reg_ack) begin
                cur.acked = 1'b1;
                cur.cycles = req_cycles;
                bus_log.push_back(cur);
                req_cycles = 0;
                ack_cyc = cyc;
            end
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] pre [2];
        int         npre;
        logic [7:0] f [5];
        int         lat;
        logic [7:0] rd;
        int         nbus;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       acked;
        int         ecyc;
        int         ntx;
        logic [7:0] tx0;
        logic [7:0] tx1;
    } vec_t;

    vec_t vt [7];

    // Random-stream reference data
    logic [7:0] stream[$];
    logic [7:0] exp_tx[$];
    bus_t       exp_bus[$];

    initial begin : main
        // pre, npre, frame, lat, rdata, nbus, we, addr, wdata, acked, req cycles, ntx, tx0, tx1
        vt[0] = '{'{8'h00,8'h00}, 0, '{8'hA5,8'h01,8'h10,8'h3C,8'h2D},  3, 8'h00, 1, 1'b1, 8'h10, 8'h3C, 1'b1, 4,      1, 8'h06, 8'h00};
        vt[1] = '{'{8'h00,8'h00}, 0, '{8'hA5,8'h02,8'h22,8'h00,8'h20},  2, 8'h5A, 1, 1'b0, 8'h22, 8'h00, 1'b1, 3,      2, 8'h06, 8'h5A};
        vt[2] = '{'{8'h00,8'h00}, 0, '{8'hA5,8'h01,8'h10,8'h3C,8'h00},  0, 8'h00, 0, 1'b0, 8'h00, 8'h00, 1'b0, 0,      1, 8'h15, 8'h00};
        vt[3] = '{'{8'h00,8'hFF}, 2, '{8'hA5,8'h01,8'h10,8'h3C,8'h2D},  0, 8'h00, 1, 1'b1, 8'h10, 8'h3C, 1'b1, 1,      1, 8'h06, 8'h00};
        vt[4] = '{'{8'h00,8'h00}, 0, '{8'hA5,8'h03,8'h11,8'h22,8'h30},  0, 8'h00, 0, 1'b0, 8'h00, 8'h00, 1'b0, 0,      1, 8'h15, 8'h00};
        vt[5] = '{'{8'h00,8'h00}, 0, '{8'hA5,8'h01,8'hA5,8'hA5,8'h01},  1, 8'h00, 1, 1'b1, 8'hA5, 8'hA5, 1'b1, 2,      1, 8'h06, 8'h00};
        vt[6] = '{'{8'h00,8'h00}, 0, '{8'hA5,8'h02,8'h33,8'h00,8'h31}, -1, 8'h00, 1, 1'b0, 8'h33, 8'h00, 1'b0, ACK_TO, 1, 8'h15, 8'h00};

        // Reset state
        reset_n = 1'b0;
        step(3);
        check("rst_rd_uart", int'(rd_uart), 0);
        check("rst_wr_uart", int'(wr_uart), 0);
        check("rst_w_data", int'(w_data), 0);
        check("rst_reg_req", int'(reg_req), 0);
        check("rst_reg_we", int'(reg_we), 0);
        check("rst_reg_addr", int'(reg_addr), 0);
        check("rst_reg_wdata", int'(reg_wdata), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(2);
        check("post_rst_busy", int'(busy), 0);

        // Table of single frames
        for (int i = 0; i < 7; i++) begin
            clear_logs();
            ack_lat = vt[i].lat;
            slave_rdata = vt[i].rd;
            for (int j = 0; j < vt[i].npre; j++) rx_q.push_back(vt[i].pre[j]);
            for (int j = 0; j < 5; j++) rx_q.push_back(vt[i].f[j]);
            wait_done(2000, $sformatf("v%0d", i));
            check($sformatf("v%0d_nbus", i), bus_log.size(), vt[i].nbus);
            if (bus_log.size() > 0 && vt[i].nbus > 0) begin
                check($sformatf("v%0d_we", i), int'(bus_log[0].we), int'(vt[i].we));
                check($sformatf("v%0d_addr", i), int'(bus_log[0].addr), int'(vt[i].addr));
                if (vt[i].we) check($sformatf("v%0d_wdata", i), int'(bus_log[0].wdata), int'(vt[i].wd));
                check($sformatf("v%0d_acked", i), int'(bus_log[0].acked), int'(vt[i].acked));
                check($sformatf("v%0d_req_cycles", i), bus_log[0].cycles, vt[i].ecyc);
            end
            check($sformatf("v%0d_ntx", i), tx_log.size(), vt[i].ntx);
            if (tx_log.size() > 0) check($sformatf("v%0d_tx0", i), int'(tx_log[0]), int'(vt[i].tx0));
            if (tx_log.size() > 1 && vt[i].ntx > 1) check($sformatf("v%0d_tx1", i), int'(tx_log[1]), int'(vt[i].tx1));
            if (i == 0) begin
                check("lat_sync_to_req", req_rise_cyc - sync_pop_cyc, 6);
                check("lat_ack_to_wr", first_wr_cyc - ack_cyc, 1);
            end
        end

        // Inter-byte timeout: partial frame dropped silently, next frame works
        clear_logs();
        rx_q.push_back(8'hA5); rx_q.push_back(8'h01);
        step(IDLE_TO - 20);
        check("to_busy_before", int'(busy), 1);
        step(40);
        check("to_busy_after", int'(busy), 0);
        check("to_no_tx", tx_log.size(), 0);
        check("to_no_bus", bus_log.size(), 0);
        ack_lat = 1;
        for (int j = 0; j < 5; j++) rx_q.push_back(vt[0].f[j]);
        wait_done(2000, "to_next");
        check("to_next_nbus", bus_log.size(), 1);
        if (bus_log.size() > 0) check("to_next_addr", int'(bus_log[0].addr), 8'h10);
        check("to_next_ntx", tx_log.size(), 1);
        if (tx_log.size() > 0) check("to_next_tx0", int'(tx_log[0]), 8'h06);

        // Ack timeout with tx FIFO full: NAK held back, then sent exactly once
        clear_logs();
        ack_lat = -1;
        txf_force = 1;
        for (int j = 0; j < 5; j++) rx_q.push_back(vt[6].f[j]);
        for (int k = 0; k < 1000 && bus_log.size() == 0; k++) step(1);
        check("stall_bus_seen", bus_log.size(), 1);
        step(20);
        check("stall_no_tx", tx_log.size(), 0);
        check("stall_busy", int'(busy), 1);
        txf_force = 0;
        wait_done(200, "stall");
        check("stall_ntx", tx_log.size(), 1);
        if (tx_log.size() > 0) check("stall_tx0", int'(tx_log[0]), 8'h15);
        if (bus_log.size() > 0) check("stall_req_cycles", bus_log[0].cycles, ACK_TO);

        // Reset during the bus phase drops reg_req without waiting for a clock
        clear_logs();
        ack_lat = -1;
        for (int j = 0; j < 5; j++) rx_q.push_back(vt[6].f[j]);
        for (int k = 0; k < 100 && req_cycles == 0; k++) step(1);
        step(5);
        check("rstbus_req_before", int'(reg_req), 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rstbus_req", int'(reg_req), 0);
        check("rstbus_busy", int'(busy), 0);
        step(2);
        reset_n = 1'b1;
        step(3);
        clear_logs();

        // Randomized frame stream
        gap_rand = 1; txf_rand = 1; slave_by_addr = 1;
        for (int f = 0; f < 40; f++) begin
            int         nstray, kind;
            logic [7:0] b, c, a, d, k;
            nstray = $urandom_range(0, 2);
            for (int s = 0; s < nstray; s++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h00;
                stream.push_back(b);
            end
            kind = $urandom_range(0, 9);
            c = (kind < 4) ? 8'h01 : (kind < 8) ? 8'h02 : 8'($urandom_range(3, 255));
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            k = c ^ a ^ d;
            if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
            stream.push_back(SYNC); stream.push_back(c); stream.push_back(a);
            stream.push_back(d); stream.push_back(k);
        end
        // Frame-level parser: hunt for SYNC, take four bytes, decide the response.
        begin
            int i = 0;
            while (i < stream.size()) begin
                logic [7:0] c, a, d, k;
                bus_t       t;
                if (stream[i] != SYNC || i + 4 >= stream.size()) begin
                    i++;
                    continue;
                end
                c = stream[i+1]; a = stream[i+2]; d = stream[i+3]; k = stream[i+4];
                i += 5;
                if ((c ^ a ^ d) != k || (c != 8'h01 && c != 8'h02)) begin
                    exp_tx.push_back(8'h15);
                end else begin
                    t.we = (c == 8'h01); t.addr = a; t.wdata = d; t.acked = 1'b1;
                    t.cycles = a % 4 + 1;
                    exp_bus.push_back(t);
                    exp_tx.push_back(8'h06);
                    if (c == 8'h02) exp_tx.push_back(rdata_of(a));
                end
            end
        end
        foreach (stream[j]) rx_q.push_back(stream[j]);
        wait_done(20000, "rand");
        check("rand_ntx", tx_log.size(), exp_tx.size());
        check("rand_nbus", bus_log.size(), exp_bus.size());
        for (int j = 0; j < tx_log.size() && j < exp_tx.size(); j++)
            check($sformatf("rand_tx%0d", j), int'(tx_log[j]), int'(exp_tx[j]));
        for (int j = 0; j < bus_log.size() && j < exp_bus.size(); j++) begin
            check($sformatf("rand_bus%0d_we", j), int'(bus_log[j].we), int'(exp_bus[j].we));
            check($sformatf("rand_bus%0d_addr", j), int'(bus_log[j].addr), int'(exp_bus[j].addr));
            if (exp_bus[j].we) check($sformatf("rand_bus%0d_wdata", j), int'(bus_log[j].wdata), int'(exp_bus[j].wdata));
            check($sformatf("rand_bus%0d_cyc", j), bus_log[j].cycles, exp_bus[j].cycles);
        end

        check("protocol_violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
